// File: rtl/load_store_unit.sv
// Load/store unit: drives the word-addressed, byte-masked data port.
// One response per accepted request; alignment, steering and extension.
`ifndef MEM_CMD_READ
`define MEM_CMD_READ 1'b0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 1'b1
`endif

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [1:0]  resp_err_code,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic        mem_enable,
    output logic        mem_cmd,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_load_data,
    input  logic        mem_valid
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state_q;
    logic        store_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  code_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] rdata_q;

    logic [1:0]  code_d;
    logic [3:0]  mask_d;
    logic [31:0] wrep_d;
    logic [31:0] shifted;
    logic [31:0] ext_d;

    always_comb begin
        code_d = 2'b00;
        if (req_size == 2'b11) begin
            code_d = 2'b10;
        end else if ((req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
            code_d = 2'b01;
        end
    end

    always_comb begin
        mask_d = 4'b1111;
        wrep_d = wdata_q;
        unique case (size_q)
            2'b00: begin
                mask_d = 4'b0001 << addr_q[1:0];
                wrep_d = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                mask_d = 4'b0011 << {addr_q[1], 1'b0};
                wrep_d = {2{wdata_q[15:0]}};
            end
            default: begin
                mask_d = 4'b1111;
                wrep_d = wdata_q;
            end
        endcase
    end

    // Half loads are aligned here, so the byte shift also selects the half.
    assign shifted = mem_load_data >> {addr_q[1:0], 3'b000};

    always_comb begin
        ext_d = mem_load_data;
        unique case (size_q)
            2'b00: ext_d = uns_q ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: ext_d = uns_q ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
            default: ext_d = mem_load_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            code_q  <= 2'b00;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        store_q <= req_store;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        code_q  <= code_d;
                        cnt_q   <= CW'(1);
                        rdata_q <= 32'h0;
                        state_q <= (code_d != 2'b00) ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (store_q) begin
                        state_q <= RESP;
                    end else if (mem_valid) begin
                        rdata_q <= ext_d;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                        code_q  <= 2'b11;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    code_q  <= 2'b00;
                    rdata_q <= 32'h0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic acc;
    logic rsp;
    assign acc = (state_q == ACCESS);
    assign rsp = (state_q == RESP);

    assign req_ready      = (state_q == IDLE);
    assign mem_enable     = acc;
    assign mem_addr       = acc ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_mask       = acc ? mask_d : 4'b0000;
    assign mem_cmd        = (acc && store_q) ? `MEM_CMD_WRITE : `MEM_CMD_READ;
    assign mem_write_data = (acc && store_q) ? wrep_d : 32'h0;
    assign resp_valid     = rsp;
    assign resp_rdata     = rsp ? rdata_q : 32'h0;
    assign resp_error     = rsp && (code_q != 2'b00);
    assign resp_err_code  = rsp ? code_q : 2'b00;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-masked memory model.
// Vector table plus hand sequences for reset during ACCESS and RESP.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [1:0]  resp_err_code;
    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    logic        mem_enable;
    logic        mem_cmd;
    logic [31:0] mem_write_data;
    logic [31:0] mem_load_data;
    logic        mem_valid;
    logic        mv_en = 1'b1;

    logic [31:0] mem [256] = '{default: 32'h0};

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_store(req_store),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_error(resp_error),
        .resp_err_code(resp_err_code),
        .mem_addr(mem_addr),
        .mem_mask(mem_mask),
        .mem_enable(mem_enable),
        .mem_cmd(mem_cmd),
        .mem_write_data(mem_write_data),
        .mem_load_data(mem_load_data),
        .mem_valid(mem_valid)
    );

    // Write command is 1, read is 0.
    assign mem_valid = mem_enable & ~mem_cmd & mv_en;
    assign mem_load_data = mem_enable ? mem[mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_enable && mem_cmd) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_mask[i])
                    mem[mem_addr[9:2]][8*i +: 8] <= mem_write_data[8*i +: 8];
            end
        end
    end

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        nomem;
        int          lat;
        int          en;
        logic [3:0]  mask;
        logic [31:0] mwd;
        logic [31:0] rd;
        logic [1:0]  code;
    } vec_t;

    function automatic vec_t mk(
        input logic st, input logic [1:0] sz, input logic un,
        input logic [31:0] addr, input logic [31:0] wd,
        input logic nomem, input int lat, input int en,
        input logic [3:0] mask, input logic [31:0] mwd,
        input logic [31:0] rd, input logic [1:0] code);
        vec_t v;
        v.st = st; v.sz = sz; v.un = un;
        v.addr = addr; v.wd = wd; v.nomem = nomem;
        v.lat = lat; v.en = en; v.mask = mask;
        v.mwd = mwd; v.rd = rd; v.code = code;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string nm);
        int cyc;
        int en;
        bit got;
        logic [3:0]  mk_s;
        logic [31:0] wd_s;
        logic [31:0] ad_s;
        logic        cm_s;
        cyc = 0; en = 0; got = 0;
        mk_s = 4'h0; wd_s = 32'h0; ad_s = 32'h0; cm_s = 1'b0;
        mv_en = !v.nomem;
        @(negedge clk);
        chk({nm, ":ready"}, 32'(req_ready), 32'd1);
        req_store = v.st;
        req_size = v.sz;
        req_unsigned = v.un;
        req_addr = v.addr;
        req_wdata = v.wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_enable) begin
                en++;
                mk_s = mem_mask;
                wd_s = mem_write_data;
                ad_s = mem_addr;
                cm_s = mem_cmd;
            end
            if (resp_valid) begin
                got = 1;
                break;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        chk({nm, ":resp_seen"}, 32'(got), 32'd1);
        chk({nm, ":latency"}, 32'(cyc + 1), 32'(v.lat));
        chk({nm, ":en_cycles"}, 32'(en), 32'(v.en));
        chk({nm, ":mask"}, 32'(mk_s), 32'(v.mask));
        chk({nm, ":mwdata"}, wd_s, v.mwd);
        chk({nm, ":maddr"}, ad_s,
            (v.en > 0) ? {v.addr[31:2], 2'b00} : 32'h0);
        chk({nm, ":mcmd"}, 32'(cm_s), (v.en > 0) ? 32'(v.st) : 32'd0);
        chk({nm, ":rdata"}, resp_rdata, v.rd);
        chk({nm, ":err"}, 32'(resp_error), 32'(v.code != 2'b00));
        chk({nm, ":code"}, 32'(resp_err_code), 32'(v.code));
        chk({nm, ":ready_in_resp"}, 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, ":resp_drop"}, 32'(resp_valid), 32'd0);
        chk({nm, ":rdata_idle"}, resp_rdata, 32'h0);
        chk({nm, ":ready_after"}, 32'(req_ready), 32'd1);
        mv_en = 1'b1;
    endtask

    vec_t vt [18];

    initial begin
        vt[0]  = mk(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 2, 1,
                    4'hF, 32'hDEADBEEF, 32'h0, 2'd0);
        vt[1]  = mk(0, 2'd2, 0, 32'h100, 32'h0, 0, 2, 1,
                    4'hF, 32'h0, 32'hDEADBEEF, 2'd0);
        vt[2]  = mk(1, 2'd0, 0, 32'h103, 32'hFFFFFF80, 0, 2, 1,
                    4'h8, 32'h80808080, 32'h0, 2'd0);
        vt[3]  = mk(0, 2'd0, 0, 32'h103, 32'h0, 0, 2, 1,
                    4'h8, 32'h0, 32'hFFFFFF80, 2'd0);
        vt[4]  = mk(0, 2'd0, 1, 32'h103, 32'h0, 0, 2, 1,
                    4'h8, 32'h0, 32'h00000080, 2'd0);
        vt[5]  = mk(1, 2'd2, 0, 32'h100, 32'h80011234, 0, 2, 1,
                    4'hF, 32'h80011234, 32'h0, 2'd0);
        vt[6]  = mk(0, 2'd1, 0, 32'h102, 32'h0, 0, 2, 1,
                    4'hC, 32'h0, 32'hFFFF8001, 2'd0);
        vt[7]  = mk(0, 2'd1, 1, 32'h102, 32'h0, 0, 2, 1,
                    4'hC, 32'h0, 32'h00008001, 2'd0);
        vt[8]  = mk(0, 2'd1, 0, 32'h100, 32'h0, 0, 2, 1,
                    4'h3, 32'h0, 32'h00001234, 2'd0);
        vt[9]  = mk(0, 2'd0, 0, 32'h101, 32'h0, 0, 2, 1,
                    4'h2, 32'h0, 32'h00000012, 2'd0);
        vt[10] = mk(1, 2'd1, 0, 32'h106, 32'h5555ABCD, 0, 2, 1,
                    4'hC, 32'hABCDABCD, 32'h0, 2'd0);
        vt[11] = mk(0, 2'd2, 0, 32'h104, 32'h0, 0, 2, 1,
                    4'hF, 32'h0, 32'hABCD0000, 2'd0);
        vt[12] = mk(0, 2'd2, 0, 32'h101, 32'h0, 0, 1, 0,
                    4'h0, 32'h0, 32'h0, 2'd1);
        vt[13] = mk(0, 2'd1, 0, 32'h103, 32'h0, 0, 1, 0,
                    4'h0, 32'h0, 32'h0, 2'd1);
        vt[14] = mk(0, 2'd3, 0, 32'h101, 32'h0, 0, 1, 0,
                    4'h0, 32'h0, 32'h0, 2'd2);
        vt[15] = mk(1, 2'd2, 0, 32'h102, 32'h1234, 0, 1, 0,
                    4'h0, 32'h0, 32'h0, 2'd1);
        vt[16] = mk(0, 2'd2, 0, 32'h200, 32'h0, 1, 5, 4,
                    4'hF, 32'h0, 32'h0, 2'd3);
        vt[17] = mk(0, 2'd2, 1, 32'h100, 32'h0, 0, 2, 1,
                    4'hF, 32'h0, 32'h80011234, 2'd0);

        repeat (3) @(negedge clk);
        chk("rst:ready", 32'(req_ready), 32'd1);
        chk("rst:resp_valid", 32'(resp_valid), 32'd0);
        chk("rst:mem_enable", 32'(mem_enable), 32'd0);
        chk("rst:mem_addr", mem_addr, 32'h0);
        chk("rst:mem_wdata", mem_write_data, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run(vt[i], $sformatf("vec%0d", i));
        end

        // Reset while a load is stalled in ACCESS.
        mv_en = 1'b0;
        @(negedge clk);
        req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h200; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstacc:enable_before", 32'(mem_enable), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstacc:enable", 32'(mem_enable), 32'd0);
        chk("rstacc:addr", mem_addr, 32'h0);
        chk("rstacc:mask", 32'(mem_mask), 32'd0);
        chk("rstacc:resp_valid", 32'(resp_valid), 32'd0);
        chk("rstacc:ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mv_en = 1'b1;
        run(vt[17], "after_rst");

        // Reset while an error response is being presented.
        @(negedge clk);
        req_store = 1'b0; req_size = 2'd3; req_addr = 32'h101;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstresp:valid_before", 32'(resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstresp:valid", 32'(resp_valid), 32'd0);
        chk("rstresp:error", 32'(resp_error), 32'd0);
        chk("rstresp:code", 32'(resp_err_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(vt[1 + 7], "after_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
